vga_timing_controller: RTL and testbench

//  Sequences the 640x480@60 VGA raster from the 25 MHz pixel clock. Holds the horizontal
//  and vertical counters and gates them with a run/stop controller. Decodes per-axis phases
//  (ACTIVE/FRONT/SYNC/BACK) into hsync, vsync, video_on, pixel coordinates and line/frame

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/vga_timing_controller_axis.sv | 51 +++++
 rtl/vga_timing_controller.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, FSM state and axis phase types for the VGA raster controller.
package vga_timing_pkg;

  localparam int CNT_W    = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  // Bounds are the exclusive end positions of the active, front-porch and sync regions.
  function automatic phase_t axis_phase(input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] active_end,
                                        input logic [CNT_W-1:0] front_end,
                                        input logic [CNT_W-1:0] sync_end);
    phase_t ph;
    if (c < active_end) begin
      ph = PH_ACTIVE;
    end else if (c < front_end) begin
      ph = PH_FRONT;
    end else if (c < sync_end) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

endpackage

// File: rtl/vga_timing_controller_axis.sv
// One raster axis: wrapping position counter with wrap pulse and next-position phase decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FRONT  = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BACK   = H_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic [CNT_W-1:0] count_nxt,
  output phase_t           phase_nxt
);

  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] FRONT_END = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(ACTIVE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(ACTIVE + FRONT + SYNC + BACK - 1);

  logic [CNT_W-1:0] count_r;

  // Next position and the phase it falls in, so the top can register aligned outputs.
  always_comb begin
    wrap      = en && (count_r == LAST);
    count_nxt = count_r;
    if (wrap) begin
      count_nxt = {CNT_W{1'b0}};
    end else if (en) begin
      count_nxt = count_r + CNT_W'(1);
    end else begin
      count_nxt = count_r;
    end
    phase_nxt = axis_phase(count_nxt, ACT_END, FRONT_END, SYNC_END);
  end

  // Position register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA raster sequencer with run/stop control and registered sync/video/tick outputs.
// Optional macro VGA_GAME_TICK_EN builds a frame divider driving game_tick.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACT_P          = H_ACTIVE,
  parameter int H_FP_P           = H_FP,
  parameter int H_SYNC_P         = H_SYNC,
  parameter int H_BP_P           = H_BP,
  parameter int V_ACT_P          = V_ACTIVE,
  parameter int V_FP_P           = V_FP,
  parameter int V_SYNC_P         = V_SYNC,
  parameter int V_BP_P           = V_BP,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int GAME_TICK_FRAMES = 6
) (
  input  logic       clk_25MHz,
  input  logic       reset_n,
  input  logic       run,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       busy,
  output logic       game_tick
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
  localparam logic             SYNC_ON  = (SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic             SYNC_OFF = ~SYNC_ON;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             cnt_en_s;
  logic             h_wrap_s;
  logic             frame_end_s;
  logic [CNT_W-1:0] h_nxt_s;
  logic [CNT_W-1:0] v_nxt_s;
  phase_t           h_ph_s;
  phase_t           v_ph_s;
  logic             act_nxt_s;
  logic             last_px_nxt_s;

  logic hsync_r, vsync_r, video_on_r, line_tick_r, frame_tick_r, busy_r;

  assign cnt_en_s = (state_r != ST_IDLE);

  vga_axis_counter #(
    .ACTIVE(H_ACT_P), .FRONT(H_FP_P), .SYNC(H_SYNC_P), .BACK(H_BP_P)
  ) u_h_axis (
    .clk      (clk_25MHz),
    .reset_n  (reset_n),
    .en       (cnt_en_s),
    .count    (pixel_x),
    .wrap     (h_wrap_s),
    .count_nxt(h_nxt_s),
    .phase_nxt(h_ph_s)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACT_P), .FRONT(V_FP_P), .SYNC(V_SYNC_P), .BACK(V_BP_P)
  ) u_v_axis (
    .clk      (clk_25MHz),
    .reset_n  (reset_n),
    .en       (h_wrap_s),
    .count    (pixel_y),
    .wrap     (frame_end_s),
    .count_nxt(v_nxt_s),
    .phase_nxt(v_ph_s)
  );

  // Run/stop decision; the frame boundary is checked first so a frame is never cut short.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          state_nxt_s = run ? ST_RUN : ST_IDLE;
        end else begin
          state_nxt_s = run ? ST_RUN : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = run ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    act_nxt_s     = (state_nxt_s != ST_IDLE);
    last_px_nxt_s = act_nxt_s && (h_nxt_s == H_LAST) && (v_nxt_s == V_LAST);
  end

  // State and outputs, decoded from the next position so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      hsync_r      <= SYNC_OFF;
      vsync_r      <= SYNC_OFF;
      video_on_r   <= 1'b0;
      line_tick_r  <= 1'b0;
      frame_tick_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      hsync_r      <= (act_nxt_s && (h_ph_s == PH_SYNC)) ? SYNC_ON : SYNC_OFF;
      vsync_r      <= (act_nxt_s && (v_ph_s == PH_SYNC)) ? SYNC_ON : SYNC_OFF;
      video_on_r   <= act_nxt_s && (h_ph_s == PH_ACTIVE) && (v_ph_s == PH_ACTIVE);
      line_tick_r  <= act_nxt_s && (h_nxt_s == H_LAST);
      frame_tick_r <= last_px_nxt_s;
      busy_r       <= act_nxt_s;
    end
  end

  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign video_on   = video_on_r;
  assign line_tick  = line_tick_r;
  assign frame_tick = frame_tick_r;
  assign busy       = busy_r;

`ifdef VGA_GAME_TICK_EN
  localparam logic [15:0] G_LAST = 16'(GAME_TICK_FRAMES - 1);

  logic [15:0] frame_cnt_r;
  logic        game_tick_r;

  // Frame divider; frame_cnt_r holds the index of the frame currently being drawn.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= 16'd0;
      game_tick_r <= 1'b0;
    end else begin
      if (state_nxt_s == ST_IDLE) begin
        frame_cnt_r <= 16'd0;
      end else if (frame_end_s) begin
        frame_cnt_r <= (frame_cnt_r == G_LAST) ? 16'd0 : frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      game_tick_r <= last_px_nxt_s && (frame_cnt_r == G_LAST);
    end
  end

  assign game_tick = game_tick_r;
`else
  assign game_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomized bench for vga_timing_controller against a frame-position reference model (reduced raster).
module tb_vga_timing_controller;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int GTF = 6;

  logic       clk_25MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       run       = 1'b0;
  logic       hsync, vsync, video_on, line_tick, frame_tick, busy, game_tick;
  logic [9:0] pixel_x, pixel_y;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_timing_controller #(
    .H_ACT_P(HA), .H_FP_P(HF), .H_SYNC_P(HS), .H_BP_P(HB),
    .V_ACT_P(VA), .V_FP_P(VF), .V_SYNC_P(VS), .V_BP_P(VB),
    .SYNC_ACTIVE_HIGH(0), .GAME_TICK_FRAMES(GTF)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .reset_n   (reset_n),
    .run       (run),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .line_tick (line_tick),
    .frame_tick(frame_tick),
    .busy      (busy),
    .game_tick (game_tick)
  );

  int checks = 0;
  int errors = 0;

  // Model: active flag, drain request, linear position within the frame, frames done this session.
  bit m_act = 1'b0;
  bit m_drain = 1'b0;
  int m_pos = 0;
  int m_sess = 0;

  // Whole-frame statistics from DUT outputs, checked at each model frame end.
  int st_cyc = 0, st_vid = 0, st_hs = 0, st_vs = 0;
  int tick_cnt = 0, game_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    st_cyc = 0; st_vid = 0; st_hs = 0; st_vs = 0;
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_drain = 1'b0; m_pos = 0; m_sess = 0;
    clear_stats();
  endtask

  task automatic model_update(input bit r);
    if (!m_act) begin
      if (r) begin
        m_act = 1'b1; m_drain = 1'b0; m_pos = 0;
        clear_stats();
      end
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      m_sess++;
      if (m_drain || !r) begin
        m_act = 1'b0; m_sess = 0;
      end
    end else begin
      m_pos++;
      m_drain = !r;
    end
  endtask

  task automatic compare_all();
    int x, y, e_hs, e_vs, e_game;
    bit last;
    x = m_act ? (m_pos % HT) : 0;
    y = m_act ? (m_pos / HT) : 0;
    last = m_act && (m_pos == FRAME - 1);
    e_hs = (m_act && x >= HA + HF && x < HA + HF + HS) ? 0 : 1;
    e_vs = (m_act && y >= VA + VF && y < VA + VF + VS) ? 0 : 1;
`ifdef VGA_GAME_TICK_EN
    e_game = (last && ((m_sess + 1) % GTF == 0)) ? 1 : 0;
`else
    e_game = 0;
`endif
    check("pixel_x", int'(pixel_x), x);
    check("pixel_y", int'(pixel_y), y);
    check("busy", int'(busy), int'(m_act));
    check("video_on", int'(video_on), (m_act && x < HA && y < VA) ? 1 : 0);
    check("hsync", int'(hsync), e_hs);
    check("vsync", int'(vsync), e_vs);
    check("line_tick", int'(line_tick), (m_act && x == HT - 1) ? 1 : 0);
    check("frame_tick", int'(frame_tick), last ? 1 : 0);
    check("game_tick", int'(game_tick), e_game);
  endtask

  task automatic step(input bit r);
    run = r;
    @(posedge clk_25MHz);
    if (reset_n) model_update(r);
    #1;
    compare_all();
    tick_cnt += int'(line_tick) + int'(frame_tick);
    game_cnt += int'(game_tick);
    if (m_act) begin
      st_cyc++;
      st_vid += int'(video_on);
      st_hs  += (hsync == 1'b0) ? 1 : 0;
      st_vs  += (vsync == 1'b0) ? 1 : 0;
      if (m_pos == FRAME - 1) begin
        check("frame_cycles", st_cyc, FRAME);
        check("frame_video_cycles", st_vid, HA * VA);
        check("frame_hsync_low", st_hs, HS * VT);
        check("frame_vsync_low", st_vs, VS * HT);
        clear_stats();
      end
    end
  endtask

  task automatic run_until_pos(input int pos, input bit r);
    int n = 0;
    while (!(m_act && m_pos == pos) && n < 2 * FRAME) begin
      step(r);
      n++;
    end
    check("wait_pos_timeout", (n < 2 * FRAME) ? 1 : 0, 1);
  endtask

  task automatic drain_to_idle();
    int n = 0;
    while (m_act && n < 2 * FRAME) begin
      step(1'b0);
      n++;
    end
    check("drain_idle_busy", int'(busy), 0);
  endtask

  initial begin
    bit r;
    // Reset state while held in reset.
    model_reset();
    repeat (3) @(posedge clk_25MHz);
    #1;
    compare_all();
    @(negedge clk_25MHz);
    reset_n = 1'b1;

    // Idle with run low: nothing moves and no ticks.
    tick_cnt = 0;
    repeat (1000) step(1'b0);
    check("idle_ticks", tick_cnt, 0);

    // Continuous running across two frames.
    repeat (2 * FRAME + 50) step(1'b1);

    // Drop run mid-frame, re-raise in drain: frames continue without a gap.
    run_until_pos(5 * HT + 10, 1'b1);
    run_until_pos(9 * HT, 1'b0);
    check("drain_busy", int'(busy), 1);
    repeat (FRAME + 7) step(1'b1);
    drain_to_idle();
    check("idle_pixel_x", int'(pixel_x), 0);

    // Randomly toggled run.
    r = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 299) == 0) r = ~r;
      step(r);
    end

    // Reset asserted mid-frame, then released and re-run.
    run_until_pos(10 * HT + 20, 1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (3) step(1'b1);
    @(negedge clk_25MHz);
    reset_n = 1'b1;
    repeat (2 * FRAME + 5) step(1'b1);
    drain_to_idle();

    // Game tick cadence over a fresh 20-frame session.
    game_cnt = 0;
    repeat (20 * FRAME) step(1'b1);
`ifdef VGA_GAME_TICK_EN
    check("game_tick_count", game_cnt, 20 / GTF);
`else
    check("game_tick_count", game_cnt, 0);
`endif
    drain_to_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
